// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_LDR = 1'b1;

   localparam int DATA_W = 16;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection; fixed priority to r0, or round-robin when MEM_ARB_RR_EN is defined.
module mem_arb_select
   import mem_arb_pkg::*;
(
   input  logic r0_req,
   input  logic r1_req,
   input  logic last_owner,
   output logic any_req,
   output logic winner
);

   assign any_req = r0_req | r1_req;

`ifdef MEM_ARB_RR_EN
   always_comb begin
      winner = r0_req ? REQ_CPU : REQ_LDR;
      if (r0_req && r1_req) begin
         winner = ~last_owner;
      end
   end
`else
   logic unused_last_owner;

   assign unused_last_owner = last_owner;
   assign winner            = r0_req ? REQ_CPU : REQ_LDR;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a fixed-latency memory port; ready pulses MEM_LAT+2 cycles after req is sampled,
// one access per MEM_LAT+3 cycles, losers stay pending. MEM_ARB_RR_EN selects round-robin instead of fixed priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_BITS = 9,
   parameter int MEM_LAT   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 r0_req,
   input  logic [31:0]          r0_addr,
   input  logic [DATA_W-1:0]    r0_wdata,
   input  logic                 r0_we,
   output logic                 r0_ready,
   output logic [DATA_W-1:0]    r0_rdata,
   input  logic                 r1_req,
   input  logic [31:0]          r1_addr,
   input  logic [DATA_W-1:0]    r1_wdata,
   input  logic                 r1_we,
   output logic                 r1_ready,
   output logic [DATA_W-1:0]    r1_rdata,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 busy,
   output logic                 owner
);

   if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_chk
      $error("mem_arbiter: MEM_LAT must be within 1..15");
   end
   if (ADDR_BITS < 1 || ADDR_BITS > 31) begin : g_addr_chk
      $error("mem_arbiter: ADDR_BITS must be within 1..31");
   end

   localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

   state_t                state, state_nxt;
   logic [3:0]            lat_cnt, lat_nxt;
   logic                  last_owner, last_nxt;
   logic                  acc_we, acc_we_nxt;
   logic                  mem_en_nxt, mem_we_nxt;
   logic [ADDR_BITS-1:0]  addr_nxt;
   logic [DATA_W-1:0]     wdata_nxt;
   logic                  owner_nxt;
   logic                  rdy0_nxt, rdy1_nxt;
   logic [DATA_W-1:0]     rd0_nxt, rd1_nxt;
   logic                  any_req, winner;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^{r0_addr[31:ADDR_BITS], r1_addr[31:ADDR_BITS]};
   assign busy             = (state != IDLE);

   mem_arb_select u_select (
      .r0_req     (r0_req),
      .r1_req     (r1_req),
      .last_owner (last_owner),
      .any_req    (any_req),
      .winner     (winner)
   );

   always_comb begin
      state_nxt  = state;
      lat_nxt    = lat_cnt;
      last_nxt   = last_owner;
      acc_we_nxt = acc_we;
      mem_en_nxt = 1'b0;
      mem_we_nxt = 1'b0;
      addr_nxt   = mem_addr;
      wdata_nxt  = mem_wdata;
      owner_nxt  = owner;
      rdy0_nxt   = 1'b0;
      rdy1_nxt   = 1'b0;
      rd0_nxt    = r0_rdata;
      rd1_nxt    = r1_rdata;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt  = ACCESS;
               lat_nxt    = LAT_INIT;
               mem_en_nxt = 1'b1;
               owner_nxt  = winner;
               if (winner == REQ_LDR) begin
                  addr_nxt   = r1_addr[ADDR_BITS-1:0];
                  wdata_nxt  = r1_wdata;
                  acc_we_nxt = r1_we;
               end else begin
                  addr_nxt   = r0_addr[ADDR_BITS-1:0];
                  wdata_nxt  = r0_wdata;
                  acc_we_nxt = r0_we;
               end
               mem_we_nxt = acc_we_nxt;
            end
         end
         ACCESS: begin
            // lat_cnt reaches zero exactly in the cycle mem_rdata is valid
            if (lat_cnt == 4'd0) begin
               state_nxt = DONE;
               if (owner == REQ_LDR) begin
                  rdy1_nxt = 1'b1;
                  if (!acc_we) rd1_nxt = mem_rdata;
               end else begin
                  rdy0_nxt = 1'b1;
                  if (!acc_we) rd0_nxt = mem_rdata;
               end
            end else begin
               lat_nxt = lat_cnt - 4'd1;
            end
         end
         DONE: begin
            last_nxt  = owner;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         lat_cnt    <= 4'd0;
         last_owner <= REQ_LDR;
         acc_we     <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         owner      <= REQ_CPU;
         r0_ready   <= 1'b0;
         r1_ready   <= 1'b0;
         r0_rdata   <= '0;
         r1_rdata   <= '0;
      end else begin
         state      <= state_nxt;
         lat_cnt    <= lat_nxt;
         last_owner <= last_nxt;
         acc_we     <= acc_we_nxt;
         mem_en     <= mem_en_nxt;
         mem_we     <= mem_we_nxt;
         mem_addr   <= addr_nxt;
         mem_wdata  <= wdata_nxt;
         owner      <= owner_nxt;
         r0_ready   <= rdy0_nxt;
         r1_ready   <= rdy1_nxt;
         r0_rdata   <= rd0_nxt;
         r1_rdata   <= rd1_nxt;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=4.
module tb_mem_arbiter;

   localparam int LAT0 = 1;
   localparam int LAT1 = 4;

   logic             clk;
   logic [1:0]       rst_n;
   logic             mem_clear;
   logic [1:0]       r0_req, r1_req, r0_we, r1_we;
   logic [1:0][31:0] r0_addr, r1_addr;
   logic [1:0][15:0] r0_wdata, r1_wdata;
   logic [1:0]       r0_ready, r1_ready, mem_en, mem_we, busy, owner;
   logic [1:0][15:0] r0_rdata, r1_rdata, mem_wdata, mem_rdata;
   logic [1:0][8:0]  mem_addr;

   int n_checks = 0;
   int n_errors = 0;

   // external memory behaviour
   logic [15:0] mem_arr [2][512];
   bit          dirty   [2][512];
   logic [15:0] pipe    [2][16];

   // reference model state
   logic [15:0] ref_mem   [2][512];
   logic [15:0] ref_rdata [2][2];
   int          ref_last  [2];

   mem_arbiter #(.ADDR_BITS(9), .MEM_LAT(LAT0)) u_dut0 (
      .clk(clk), .rst_n(rst_n[0]),
      .r0_req(r0_req[0]), .r0_addr(r0_addr[0]), .r0_wdata(r0_wdata[0]), .r0_we(r0_we[0]),
      .r0_ready(r0_ready[0]), .r0_rdata(r0_rdata[0]),
      .r1_req(r1_req[0]), .r1_addr(r1_addr[0]), .r1_wdata(r1_wdata[0]), .r1_we(r1_we[0]),
      .r1_ready(r1_ready[0]), .r1_rdata(r1_rdata[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_rdata(mem_rdata[0]), .busy(busy[0]), .owner(owner[0])
   );

   mem_arbiter #(.ADDR_BITS(9), .MEM_LAT(LAT1)) u_dut1 (
      .clk(clk), .rst_n(rst_n[1]),
      .r0_req(r0_req[1]), .r0_addr(r0_addr[1]), .r0_wdata(r0_wdata[1]), .r0_we(r0_we[1]),
      .r0_ready(r0_ready[1]), .r0_rdata(r0_rdata[1]),
      .r1_req(r1_req[1]), .r1_addr(r1_addr[1]), .r1_wdata(r1_wdata[1]), .r1_we(r1_we[1]),
      .r1_ready(r1_ready[1]), .r1_rdata(r1_rdata[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_rdata(mem_rdata[1]), .busy(busy[1]), .owner(owner[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] seed(input int i, input int a);
      if (a == 3) return 16'hBEEF;
      return 16'((a * 613 + i * 4099 + 77) & 32'hFFFF);
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mem_clear) begin
            for (int a = 0; a < 512; a++) dirty[i][a] <= 1'b0;
         end else if (mem_en[i] && mem_we[i]) begin
            mem_arr[i][mem_addr[i]] <= mem_wdata[i];
            dirty[i][mem_addr[i]]   <= 1'b1;
         end
         pipe[i][0] <= dirty[i][mem_addr[i]] ? mem_arr[i][mem_addr[i]] : seed(i, int'(mem_addr[i]));
         for (int k = 1; k < 16; k++) pipe[i][k] <= pipe[i][k-1];
      end
   end

   assign mem_rdata[0] = pipe[0][LAT0-1];
   assign mem_rdata[1] = pipe[1][LAT1-1];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Winner per the arbitration rules.
   function automatic int pick(input logic q0, input logic q1, input int last);
      if (q0 && q1) begin
`ifdef MEM_ARB_RR_EN
         return (last == 1) ? 0 : 1;
`else
         return 0;
`endif
      end
      return q0 ? 0 : 1;
   endfunction

   function automatic logic [63:0] outs(input int d);
      return 64'({mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d], r0_ready[d], r1_ready[d],
                  r0_rdata[d], r1_rdata[d], busy[d], owner[d]});
   endfunction

   task automatic set_req(input int d, input int r, input logic we, input logic [31:0] a, input logic [15:0] wd);
      if (r == 1) begin
         r1_we[d] = we; r1_addr[d] = a; r1_wdata[d] = wd; r1_req[d] = 1'b1;
      end else begin
         r0_we[d] = we; r0_addr[d] = a; r0_wdata[d] = wd; r0_req[d] = 1'b1;
      end
   endtask

   task automatic rand_req(input int d, input int r);
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 15));
      set_req(d, r, 1'($urandom % 2), a, 16'($urandom));
   endtask

   // Called at the negedge of an IDLE cycle with requests already driven.
   task automatic access(input int d, input bit drop_early, output int w);
      int          lat, en_cnt, we_cnt, rdy_cyc, win_rdy, lose_rdy;
      logic        we;
      logic [8:0]  a;
      logic [15:0] wd, exp_rd;
      w      = pick(r0_req[d], r1_req[d], ref_last[d]);
      we     = (w == 1) ? r1_we[d] : r0_we[d];
      a      = 9'(((w == 1) ? r1_addr[d] : r0_addr[d]) % 512);
      wd     = (w == 1) ? r1_wdata[d] : r0_wdata[d];
      lat    = (d == 0) ? LAT0 : LAT1;
      exp_rd = we ? ref_rdata[d][w] : ref_mem[d][a];
      en_cnt = 0; we_cnt = 0; rdy_cyc = 0; win_rdy = 0; lose_rdy = 0;
      for (int cyc = 1; cyc <= lat + 3; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         en_cnt += int'(mem_en[d]);
         we_cnt += int'(mem_we[d]);
         if (cyc == 1) begin
            check("mem_en_c1", 64'(mem_en[d]), 64'd1);
            check("owner", 64'(owner[d]), 64'(w));
            check("mem_addr", 64'(mem_addr[d]), 64'(a));
            if (we) check("mem_wdata", 64'(mem_wdata[d]), 64'(wd));
         end
         if ((w == 1) ? r1_ready[d] : r0_ready[d]) begin
            win_rdy++;
            if (rdy_cyc == 0) rdy_cyc = cyc;
            check("rdata_at_ready", 64'((w == 1) ? r1_rdata[d] : r0_rdata[d]), 64'(exp_rd));
         end
         if ((w == 1) ? r0_ready[d] : r1_ready[d]) lose_rdy++;
         if (cyc == lat + 2) check("busy_done", 64'(busy[d]), 64'd1);
         if ((drop_early && cyc == 2) || cyc == lat + 2) begin
            if (w == 1) r1_req[d] = 1'b0; else r0_req[d] = 1'b0;
         end
      end
      check("busy_idle", 64'(busy[d]), 64'd0);
      check("n_mem_en", 64'(en_cnt), 64'd1);
      check("n_mem_we", 64'(we_cnt), 64'(we));
      check("ready_cycle", 64'(rdy_cyc), 64'(lat + 2));
      check("ready_width", 64'(win_rdy), 64'd1);
      check("loser_ready", 64'(lose_rdy), 64'd0);
      if (we) ref_mem[d][a] = wd;
      else    ref_rdata[d][w] = ref_mem[d][a];
      ref_last[d] = w;
      check("r0_rdata_hold", 64'(r0_rdata[d]), 64'(ref_rdata[d][0]));
      check("r1_rdata_hold", 64'(r1_rdata[d]), 64'(ref_rdata[d][1]));
   endtask

   task automatic drain(input int d);
      int w;
      for (int n = 0; n < 4; n++) begin
         if (r0_req[d] || r1_req[d]) access(d, 1'b0, w);
      end
      check("drained", 64'({r0_req[d], r1_req[d]}), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w, rdy;
      logic [3:0]  seq, exp_seq;
      rst_n = 2'b00; mem_clear = 1'b1;
      r0_req = '0; r1_req = '0; r0_we = '0; r1_we = '0;
      r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
      for (int i = 0; i < 2; i++) begin
         ref_last[i] = 1; ref_rdata[i][0] = '0; ref_rdata[i][1] = '0;
         for (int a = 0; a < 512; a++) ref_mem[i][a] = seed(i, a);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outs0", outs(0), 64'd0);
      check("reset_outs1", outs(1), 64'd0);
      mem_clear = 1'b0;
      rst_n = 2'b11;
      @(posedge clk);
      @(negedge clk);
      check("idle_busy", 64'(busy[0]), 64'd0);

      // single read of 0x003
      set_req(0, 0, 1'b0, 32'h0000_0003, 16'h0);
      access(0, 1'b0, w);
      check("single_read", 64'(r0_rdata[0]), 64'hBEEF);

      // write then read back through r1
      set_req(0, 1, 1'b1, 32'h0000_01FF, 16'h1234);
      access(0, 1'b0, w);
      set_req(0, 1, 1'b0, 32'h0000_01FF, 16'h0);
      access(0, 1'b0, w);
      check("readback", 64'(r1_rdata[0]), 64'h1234);
      check("r0_untouched", 64'(r0_rdata[0]), 64'hBEEF);

      // address wrap
      set_req(0, 0, 1'b0, 32'h0000_0205, 16'h0);
      access(0, 1'b0, w);

      // request dropped mid-access still completes
      set_req(0, 1, 1'b0, 32'h0000_0003, 16'h0);
      access(0, 1'b1, w);

      // contention: both requesters keep asking
      seq = '0;
      for (int k = 0; k < 4; k++) begin
         if (!r0_req[0]) rand_req(0, 0);
         if (!r1_req[0]) rand_req(0, 1);
         access(0, 1'b0, w);
         seq[k] = (w == 1);
      end
`ifdef MEM_ARB_RR_EN
      exp_seq = 4'b1010;
`else
      exp_seq = 4'b0000;
`endif
      check("grant_seq", 64'(seq), 64'(exp_seq));
      drain(0);

      // randomized traffic on both latencies
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 24; n++) begin
            if (!r0_req[d] && ($urandom % 2 == 1)) rand_req(d, 0);
            if (!r1_req[d] && ($urandom % 2 == 1)) rand_req(d, 1);
            if (!r0_req[d] && !r1_req[d]) rand_req(d, int'($urandom % 2));
            access(d, ($urandom % 4) == 0, w);
         end
         drain(d);
      end

      // reset in the middle of a MEM_LAT=4 access
      set_req(1, 0, 1'b0, 32'h0000_0003, 16'h0);
      @(posedge clk);
      @(negedge clk);
      check("rst_test_en", 64'(mem_en[1]), 64'd1);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("rst_test_busy", 64'(busy[1]), 64'd1);
      rst_n[1] = 1'b0;
      #1;
      check("rst_mid_outs", outs(1), 64'd0);
      r0_req[1] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n[1] = 1'b1;
      rdy = 0;
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         rdy += int'(r0_ready[1] | r1_ready[1]);
      end
      check("rst_no_ready", 64'(rdy), 64'd0);
      check("rst_busy", 64'(busy[1]), 64'd0);
      ref_last[1] = 1; ref_rdata[1][0] = '0; ref_rdata[1][1] = '0;

      // first contest after reset goes to r0 in either mode
      rand_req(1, 0);
      rand_req(1, 1);
      access(1, 1'b0, w);
      check("post_rst_winner", 64'(owner[1]), 64'd0);
      drain(1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
